// File: rtl/hilo_mdu.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one accumulator/shift register pair.
module hilo_mdu #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW       = $clog2(WIDTH) + 1;
    localparam bit ITER_MUL = (MUL_ITER != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_op_mul;
    logic             w_op_div;
    logic             w_is_md;
    logic             w_accept;
    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_q_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_last;
    logic             w_fast_en;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_op_mul    = (op_i == OP_MULT) | (op_i == OP_MULTU);
    assign w_op_div    = (op_i == OP_DIV) | (op_i == OP_DIVU);
    assign w_is_md     = w_op_div | (w_op_mul & ITER_MUL);
    assign w_accept    = (r_state == S_IDLE) & start_i & ~flush_i;
    assign w_signed_op = (op_i == OP_MULT) | (op_i == OP_DIV);
    assign w_a_neg     = w_signed_op & a_i[WIDTH-1];
    assign w_b_neg     = w_signed_op & b_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -a_i : a_i;
    assign w_b_mag     = w_b_neg ? -b_i : b_i;

    assign stall_o = rst & start_i & w_is_md & (r_state != S_DONE) & ~flush_i;
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = r_done;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

    // Multiply: r_acc is the running upper half, r_q shifts the multiplier out and product in.
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // Divide: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_diff[WIDTH];

    always_comb begin
        w_acc_step = w_mul_sum[WIDTH:1];
        w_q_step   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        if (r_is_div) begin
            w_acc_step = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            w_q_step   = {r_q[WIDTH-2:0], w_div_ge};
        end
    end

    // A zero divisor naturally leaves |a| as remainder; sign fix then restores a_i exactly.
    assign w_prod     = {w_acc_step, w_q_step};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_q_step : w_q_step);
    assign w_rem_fix  = r_neg_r ? -w_acc_step : w_acc_step;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    generate
        if (ITER_MUL) begin : g_iter_mul
            assign w_fast_en   = 1'b0;
            assign w_fast_prod = '0;
        end else begin : g_fast_mul
            logic [2*WIDTH-1:0] w_a_ext;
            logic [2*WIDTH-1:0] w_b_ext;
            assign w_a_ext     = {{WIDTH{w_signed_op & a_i[WIDTH-1]}}, a_i};
            assign w_b_ext     = {{WIDTH{w_signed_op & b_i[WIDTH-1]}}, b_i};
            assign w_fast_en   = w_op_mul;
            assign w_fast_prod = w_a_ext * w_b_ext;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_md) begin
                            r_acc    <= '0;
                            r_q      <= w_op_div ? w_a_mag : w_b_mag;
                            r_b      <= w_op_div ? w_b_mag : w_a_mag;
                            r_is_div <= w_op_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_dz     <= w_op_div & (b_i == '0);
                            r_cnt    <= '0;
                            r_state  <= S_BUSY;
                        end else if (w_fast_en) begin
                            {r_hi, r_lo} <= w_fast_prod;
                            r_done       <= 1'b1;
                        end else if (op_i == OP_MTHI) begin
                            r_hi <= a_i;
                        end else if (op_i == OP_MTLO) begin
                            r_lo <= a_i;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_step;
                        r_q   <= w_q_step;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            if (r_is_div) begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end else begin
                                {r_hi, r_lo} <= w_prod_fix;
                            end
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
